// File: rtl/hp_alarm_evlog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hp_alarm_evlog : timestamps alarm rising edges into a Wishbone-drained FIFO.
// Optional macro HP_EVLOG_DROP_CTR_EN adds a saturating drop counter.
// Rev 1.0
// ----------------------------------------------------------------------------
module hp_alarm_evlog #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0010,
  parameter int          DEPTH        = 16,
  parameter int          TS_W         = 24
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        alarm_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [2:0]      sync_q, sync_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enable_q, enable_d;
  logic            irq_en_q, irq_en_d;
  logic            overflow_q, overflow_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            irq_q, irq_d;
  logic [TS_W-1:0] mem_q [DEPTH];

  logic        addr_ctrl, addr_event, addr_time;
  logic        req, rd_req, ctrl_wr, clear;
  logic        empty, full, alarm_edge, push, pop, drop;
  logic [7:0]  drop_field;
  logic [31:0] status, rdata;
  logic        unused_wdat;

  assign unused_wdat = ^wbs_dat_i[31:3];

  always_comb begin
    addr_ctrl  = (wbs_adr_i == BASE_ADDRESS);
    addr_event = (wbs_adr_i == BASE_ADDRESS + 32'd4);
    addr_time  = (wbs_adr_i == BASE_ADDRESS + 32'd8);
    // Gating with !ack_q turns a held strobe into one completion every two clocks.
    req        = wbs_cyc_i & wbs_stb_i & (addr_ctrl | addr_event | addr_time) & ~ack_q;
    rd_req     = req & ~wbs_we_i;
    ctrl_wr    = req & wbs_we_i & addr_ctrl;
    clear      = ctrl_wr & wbs_dat_i[1];
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    alarm_edge = sync_q[1] & ~sync_q[2];
    pop        = rd_req & addr_event & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push       = alarm_edge & enable_q & (~full | pop) & ~clear;
    drop       = alarm_edge & enable_q & full & ~pop & ~clear;
  end

  always_comb begin
    status        = '0;
    status[0]     = enable_q;
    status[2]     = irq_en_q;
    status[3]     = empty;
    status[4]     = full;
    status[5]     = overflow_q;
    status[15:8]  = 8'(count_q);
    status[23:16] = drop_field;
    if (addr_ctrl) begin
      rdata = status;
    end else if (addr_event) begin
      rdata = empty ? 32'h0 : {1'b1, 7'b0, 24'(mem_q[rd_ptr_q])};
    end else begin
      rdata = 32'(ts_q);
    end
  end

  always_comb begin
    sync_d     = {sync_q[1:0], alarm_i};
    ts_d       = ts_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q | drop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (enable_q) ts_d = ts_q + TS_W'(1);
    if (ctrl_wr) begin
      enable_d = wbs_dat_i[0];
      irq_en_d = wbs_dat_i[2];
    end

    if (clear) begin
      ts_d       = '0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    ack_d = req;
    dat_d = rd_req ? rdata : 32'h0;
    irq_d = irq_en_q & ~empty;
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= ts_q;
  end

`ifdef HP_EVLOG_DROP_CTR_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear)                             drop_cnt_d = 8'h00;
    else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'h01;
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) drop_cnt_q <= 8'h00;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_field = drop_cnt_q;
`else
  assign drop_field = 8'h00;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: doc/hp_alarm_evlog.md
Name: hp_alarm_evlog

Overview:
- Downstream consumer of the glitch-detector alarm (`hp_Alarm`); timestamps each alarm rising edge and buffers events in a FIFO.
- Firmware drains the FIFO over Wishbone, so it sees when glitches were detected, not just a count.
- Sits beside the detector's Wishbone slave on the same bus, at its own base address.

Parameters:
- BASE_ADDRESS, 32'h3000_0010, word-aligned base of the 3-register window.
- DEPTH, 16, FIFO entries; power of two, 2..128.
- TS_W, 24, timestamp width in bits, 8..24.

Ports:
- wb_clk_i  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- alarm_i  in  1  raw alarm from detector; asynchronous to wb_clk_i.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  level interrupt: events pending.

Behaviour:
- Reset (async, active-high) clears everything:
  - synchronizer and timestamp counter.
  - FIFO pointers and count.
  - enable, irq_en, overflow.
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- Register map (offsets from BASE_ADDRESS):
  - 0x0 CTRL/STATUS.
  - 0x4 EVENT (read pops).
  - 0x8 TIME (read-only current timestamp).
  - Any other address: no ack.
- alarm_i path:
  - 2-flop synchronizer, then a third flop for rising-edge detect.
  - Push occurs on the edge 3 clocks after alarm_i rises.
  - Pulses shorter than one clock may be missed. The detector's own latch covers that case.
- Timestamp counter:
  - Increments every clock while enable=1; holds while enable=0.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - The entry stores the counter value on the push cycle.
- Push rules:
  - Push if edge && enable && !full.
  - Edge while full: event dropped, overflow sticky bit set, FIFO unchanged.
  - Edge while enable=0: ignored, no overflow.
- Pop: on the clock that asserts ack for a read of EVENT when !empty.
- EVENT read data:
  - Non-empty: {1'b1, 7'b0, zero-extended ts} = the head entry.
  - Empty: 32'h0 (valid bit 0), no pop, no error.
- Simultaneous push and pop: both performed, count unchanged.
  - Push into a full FIFO on the same cycle as a pop succeeds; no overflow.
- CTRL write fields:
  - bit0 enable.
  - bit1 clear: self-clearing; flushes FIFO, clears overflow, zeroes timestamp on the write cycle. A push in that same cycle is discarded.
  - bit2 irq_en.
- STATUS read fields:
  - bit0 enable, bit2 irq_en, bit3 empty, bit4 full, bit5 overflow.
  - [15:8] count, zero-extended; count reaches DEPTH when full.
  - Other bits 0.
- Writes to EVENT and TIME are acked and ignored.
- Handshake:
  - wbs_ack_o <= cyc & stb & addr_hit & !wbs_ack_o, i.e. 1-cycle latency, single-cycle pulse.
  - A held strobe completes once every 2 clocks; each completion pops at most once.
- wbs_dat_o:
  - Registered on the ack-setting edge for reads.
  - 0 in all other cycles.
- irq_o: registered, = irq_en & !empty; valid one cycle after the state changes.
- Reset mid-transaction: ack drops immediately; the FIFO is flushed.

Optional Feature:
- Macro: HP_EVLOG_DROP_CTR_EN.
- Defined:
  - 8-bit saturating drop counter (stops at 255), incremented on each event discarded due to full.
  - Readable at STATUS[23:16]; cleared by reset or CTRL.clear.
- Undefined:
  - No counter; STATUS[23:16] reads 0.
  - Overflow bit behaves identically in both builds.

Test Plan:
- Enable, then pulse alarm_i high 4 clocks at timestamp ~100 -> one entry; EVENT read = 0x8000_0000 | ts, with ts = counter value 3 clocks after the rise; STATUS.count 1 -> 0.
- With irq_en=1, generate 3 edges -> irq_o=1 from 1 cycle after the first push; 3 EVENT reads return increasing ts; irq_o=0 one cycle after the last pop; 4th read = 0x0.
- Generate DEPTH+2 = 18 edges with no reads -> full=1, overflow=1, count=16; with the macro, STATUS[23:16]=2; the first read returns the first event.
- FIFO full and an edge on the same clock as an EVENT-read ack -> count stays 16, overflow stays 0, newest ts stored at tail.
- Set TIME via CTRL.clear, run 2^TS_W clocks -> TIME wraps to 0; an event after the wrap records a small ts.
- Assert reset during a held read strobe -> wbs_ack_o and wbs_dat_o 0 immediately; STATUS afterwards = 0x0000_0008 (empty only).
